// File: rtl/dmem_port_arbiter_if.sv
// Requester, stall and memory-side signals of the shared instruction/data memory port.
interface dmem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_stall;
  logic        FREEZE;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        timeout_err;

  // master: the arbiter; slave: the requesters and the memory around it
  modport master (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_stall, dm_rdata, dm_stall, FREEZE,
           mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );
  modport slave (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_stall, dm_rdata, dm_stall, FREEZE,
           mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction fetch and the
// MEM-stage data port; data has priority, with a fetch starvation guard and an ack watchdog.
module dmem_port_arbiter #(
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNT_W      = 7
) (
  input logic                 CLK,
  input logic                 RESET,
  dmem_port_arbiter_if.master bus
);
  localparam int unsigned SW = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OWN_DM, OWN_IF} owner_t;

  state_t           state;
  owner_t           owner;
  logic [SW-1:0]    streak;
  logic [CNT_W-1:0] watchdog;
  logic             mem_req, mem_we, timeout_err;
  logic [31:0]      mem_addr, mem_wdata, if_rdata, dm_rdata;
  logic             dm_req, dm_win, in_done;

  assign dm_req  = bus.dm_read | bus.dm_write;
  assign dm_win  = dm_req && !(bus.if_req && streak == SW'(MAX_STREAK));
  assign in_done = (state == DONE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      owner       <= OWN_DM;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      streak      <= '0;
      watchdog    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_win) begin
            owner     <= OWN_DM;
            mem_addr  <= bus.dm_addr;
            mem_we    <= bus.dm_write;
            mem_wdata <= bus.dm_wdata;
            mem_req   <= 1'b1;
            state     <= BUSY;
            if (!bus.if_req)
              streak <= '0;
            else if (streak != SW'(MAX_STREAK))
              streak <= streak + 1'b1;
          end else if (bus.if_req) begin
            owner     <= OWN_IF;
            mem_addr  <= bus.if_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_req   <= 1'b1;
            state     <= BUSY;
            streak    <= '0;
          end
        end
        BUSY: begin
          // an ack in the watchdog's last cycle still counts as a normal completion
          if (bus.mem_ack) begin
            if (owner == OWN_IF)
              if_rdata <= bus.mem_rdata;
            else if (!mem_we)
              dm_rdata <= bus.mem_rdata;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            watchdog <= '0;
            state    <= DONE;
          end else if (watchdog == CNT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            if (owner == OWN_IF)
              if_rdata <= '0;
            else
              dm_rdata <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            watchdog <= '0;
            state    <= DONE;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_stall    = bus.if_req & !(in_done && owner == OWN_IF);
  assign bus.dm_stall    = dm_req & !(in_done && owner == OWN_DM);
  assign bus.FREEZE      = bus.if_stall | bus.dm_stall;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.if_rdata    = if_rdata;
  assign bus.dm_rdata    = dm_rdata;
  assign bus.timeout_err = timeout_err;
endmodule
